// File: rtl/bus_demux_1x4.sv
// bus_demux_1x4: routes one MEM-stage load/store to one of four targets
// by address decode and returns that target's response, one at a time.
module bus_demux_1x4 #(
  parameter logic [31:0] BASE0   = 32'h0000_0000,
  parameter logic [31:0] MASK0   = 32'hFFFF_0000,
  parameter logic [31:0] BASE1   = 32'h8000_0000,
  parameter logic [31:0] MASK1   = 32'hFFFF_FFF0,
  parameter logic [31:0] BASE2   = 32'h8000_0010,
  parameter logic [31:0] MASK2   = 32'hFFFF_FFF0,
  parameter logic [31:0] BASE3   = 32'h8000_0100,
  parameter logic [31:0] MASK3   = 32'hFFFF_FF00,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  input  logic         req_we,
  input  logic [3:0]   req_be,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic         resp_err,
  output logic [3:0]   s_valid,
  input  logic [3:0]   s_ready,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  output logic         s_we,
  output logic [3:0]   s_be,
  input  logic [3:0]   s_resp_valid,
  input  logic [127:0] s_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  s_valid_q, s_valid_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic        s_we_q, s_we_d;
  logic [3:0]  s_be_q, s_be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [3:0]  hit;
  logic        dec_hit;
  logic [1:0]  dec_sel;
  logic        timed_out;
  logic [6:0]  rd_lsb;
  logic [31:0] sel_rdata;

  assign hit[0] = (req_addr & MASK0) == BASE0;
  assign hit[1] = (req_addr & MASK1) == BASE1;
  assign hit[2] = (req_addr & MASK2) == BASE2;
  assign hit[3] = (req_addr & MASK3) == BASE3;
  assign dec_hit = |hit;

  // lowest-index target wins when address windows overlap
  always_comb begin
    dec_sel = 2'd0;
    if (hit[0])      dec_sel = 2'd0;
    else if (hit[1]) dec_sel = 2'd1;
    else if (hit[2]) dec_sel = 2'd2;
    else if (hit[3]) dec_sel = 2'd3;
  end

  // >= rather than == so a response phase entered at the limit still ends
  assign timed_out = timer_q >= TIMEOUT;
  assign rd_lsb    = {sel_q, 5'd0};
  assign sel_rdata = s_rdata[rd_lsb +: 32];

  // next-state, payload capture, watchdog and response generation
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    timer_d      = timer_q;
    s_valid_d    = s_valid_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_we_d       = s_we_q;
    s_be_d       = s_be_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          s_addr_d  = req_addr;
          s_wdata_d = req_wdata;
          s_we_d    = req_we;
          s_be_d    = req_be;
          sel_d     = dec_sel;
          if (dec_hit) begin
            state_d   = REQ;
            s_valid_d = 4'b0001 << dec_sel;
            timer_d   = 8'd0;
          end else begin
            state_d = ERR;
          end
        end
      end
      REQ: begin
        timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
        if (s_ready[sel_q]) begin
          s_valid_d = 4'b0000;
          state_d   = RESP;
        end else if (timed_out) begin
          s_valid_d    = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
          state_d      = IDLE;
        end
      end
      RESP: begin
        timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
        if (s_resp_valid[sel_q]) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = s_we_q ? 32'd0 : sel_rdata;
          state_d      = IDLE;
        end else if (timed_out) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
          state_d      = IDLE;
        end
      end
      ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = 32'd0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      timer_q      <= 8'd0;
      s_valid_q    <= 4'b0000;
      s_addr_q     <= 32'd0;
      s_wdata_q    <= 32'd0;
      s_we_q       <= 1'b0;
      s_be_q       <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      timer_q      <= timer_d;
      s_valid_q    <= s_valid_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_we_q       <= s_we_d;
      s_be_q       <= s_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = state_q == IDLE;
  assign s_valid    = s_valid_q;
  assign s_addr     = s_addr_q;
  assign s_wdata    = s_wdata_q;
  assign s_we       = s_we_q;
  assign s_be       = s_be_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
